// File: rtl/dsm_pkg.sv
// Constants shared by the delta-sigma modulator and its CIC demodulator:
// 20-bit sample format ([19:16] sat/sign, [15] = 1 V, [14:0] fraction).
package dsm_pkg;

   localparam int                   SAMPLE_W   = 20;
   localparam logic [SAMPLE_W-1:0]  VIN_FS     = 20'h0_8000;
   localparam logic [SAMPLE_W-1:0]  VIN_FS_NEG = 20'hF_8000;
   localparam int                   SAT_MSB    = 19;
   localparam int                   VOLT_BIT   = 15;

   typedef enum logic {
      CIC_INTEG = 1'b0,
      CIC_COMB  = 1'b1
   } cic_mode_e;

   // Right shift that maps a sinc^3 full-scale of R^3 onto VIN_FS.
   function automatic int cic_shift(input int log2_r);
      return 3 * log2_r - 15;
   endfunction

endpackage

// File: rtl/dsm_cic_stage.sv
// One CIC stage: a modulo-2^W integrator or a first-difference comb.
// o_data is the stage result for this cycle; the state register updates on i_en.
module dsm_cic_stage
   import dsm_pkg::*;
#(
   parameter int        W    = 20,
   parameter cic_mode_e MODE = CIC_INTEG
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_en,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data
);

   logic [W-1:0] r_state;

   generate
      if (MODE == CIC_INTEG) begin : g_integ
         // Result is the updated accumulator so the next stage can cascade on it.
         assign o_data = r_state + i_data;

         always_ff @(posedge clk) begin
            if (reset)
               r_state <= '0;
            else if (i_en)
               r_state <= o_data;
         end
      end else begin : g_comb
         assign o_data = i_data - r_state;

         always_ff @(posedge clk) begin
            if (reset)
               r_state <= '0;
            else if (i_en)
               r_state <= i_data;
         end
      end
   endgenerate

endmodule

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator turning the DSM 1-bit stream back into 20-bit
// samples in the DSM input format, one sample per 2^LOG2_R accepted bits.
module dsm_cic_decimator
   import dsm_pkg::*;
#(
   parameter int LOG2_R = 6,
   parameter int ACC_W  = 3 * LOG2_R + 2,
   parameter int SETTLE = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                bit_in,
   input  logic                bit_valid,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid
);

   localparam int                SHIFT       = cic_shift(LOG2_R);
   localparam int                SET_W       = $clog2(SETTLE + 2);
   localparam logic [LOG2_R-1:0] CNT_LAST    = '1;
   localparam logic [SET_W-1:0]  SETTLE_DONE = SET_W'(SETTLE);

   logic [LOG2_R-1:0]   r_cnt;
   logic                r_dec_strb;
   logic [SET_W-1:0]    r_settle;
   logic [ACC_W-1:0]    r_frame_i3;
   logic [SAMPLE_W-1:0] r_sample;
   logic                r_sample_valid;

   logic                w_frame_end;
   logic [ACC_W-1:0]    w_x;
   logic [ACC_W-1:0]    w_int [0:3];
   logic [ACC_W-1:0]    w_cmb [0:3];
   logic [SAMPLE_W-1:0] w_scaled;

   assign w_frame_end = bit_valid && (r_cnt == CNT_LAST);
   assign w_x         = bit_in ? ACC_W'(1) : '1;
   assign w_int[0]    = w_x;
   // Holds the integrator output as it stood right after the frame's last bit,
   // i.e. the registered i3 seen during the strobe cycle.
   assign w_cmb[0]    = r_frame_i3;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_stage
         dsm_cic_stage #(.W(ACC_W), .MODE(CIC_INTEG)) u_integ (
            .clk    (clk),
            .reset  (reset),
            .i_en   (bit_valid),
            .i_data (w_int[gi]),
            .o_data (w_int[gi+1])
         );

         dsm_cic_stage #(.W(ACC_W), .MODE(CIC_COMB)) u_comb (
            .clk    (clk),
            .reset  (reset),
            .i_en   (r_dec_strb),
            .i_data (w_cmb[gi]),
            .o_data (w_cmb[gi+1])
         );
      end
   endgenerate

   // Arithmetic shift (floor), then sign-extend or truncate to the sample width.
   assign w_scaled = SAMPLE_W'($signed(w_cmb[3]) >>> SHIFT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt          <= '0;
         r_dec_strb     <= 1'b0;
         r_settle       <= '0;
         r_frame_i3     <= '0;
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         r_dec_strb     <= w_frame_end;
         r_sample_valid <= 1'b0;
         if (bit_valid)
            r_cnt <= r_cnt + 1'b1;
         if (w_frame_end)
            r_frame_i3 <= w_int[3];
         if (r_dec_strb) begin
            if (r_settle != SETTLE_DONE) begin
               r_settle <= r_settle + 1'b1;
            end else begin
               r_sample       <= w_scaled;
               r_sample_valid <= 1'b1;
            end
         end
      end
   end

   assign sample_out   = r_sample;
   assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Bench for dsm_cic_decimator: sinc^3 convolution model over the accepted
// bit history, compared against the DUT every cycle, plus literal checks.
module tb_dsm_cic_decimator;
   import dsm_pkg::*;

   localparam int LOG2_R = 6;
   localparam int R      = 1 << LOG2_R;
   localparam int KLEN   = 3 * R - 2;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        bit_in    = 1'b0;
   logic        bit_valid = 1'b0;
   logic [19:0] sample_out;
   logic        sample_valid;

   dsm_cic_decimator #(.LOG2_R(LOG2_R)) dut (
      .clk          (clk),
      .reset        (reset),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .sample_out   (sample_out),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state
   int          h [KLEN];
   int          xq[$];
   int          edge_cnt = 0;
   int          nbits = 0;
   int          frames = 0;
   int          due_edge = -1;
   logic [19:0] due_val = '0;
   logic [19:0] exp_out = '0;
   logic        exp_valid = 1'b0;
   bit          armed = 1'b0;

   // Observations since last reset
   logic [19:0] last_sample = '0;
   int          nvalid = 0;
   int          first_valid_edge = -1;
   int          last_valid_edge = -1;
   int          last_spacing = -1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, exp, edge_cnt);
      end
   endtask

   // Output at a frame end = sinc^3 kernel applied to the most recent bits (zero history before reset).
   function automatic logic [19:0] model_frame();
      int acc = 0;
      int n = xq.size();
      for (int k = 0; k < KLEN; k++)
         if (n - 1 - k >= 0)
            acc += h[k] * xq[n - 1 - k];
      return 20'(acc >>> (3 * LOG2_R - 15));
   endfunction

   // Model update on every posedge, comparison on the following negedge.
   initial begin
      forever begin
         @(posedge clk);
         edge_cnt++;
         if (reset) begin
            xq.delete();
            nbits = 0; frames = 0; due_edge = -1;
            exp_valid = 1'b0; exp_out = '0;
            nvalid = 0; first_valid_edge = -1; last_valid_edge = -1; last_spacing = -1;
            armed = 1'b1;
         end else begin
            exp_valid = (due_edge == edge_cnt);
            if (exp_valid) exp_out = due_val;
            if (bit_valid) begin
               xq.push_back(bit_in ? 1 : -1);
               if (xq.size() > KLEN) void'(xq.pop_front());
               nbits++;
               if (nbits % R == 0) begin
                  frames++;
                  if (frames > 3) begin
                     due_edge = edge_cnt + 1;
                     due_val  = model_frame();
                  end
               end
            end
         end
         @(negedge clk);
         if (armed) begin
            check("sample_valid", 32'(sample_valid), 32'(exp_valid));
            check("sample_out", 32'(sample_out), 32'(exp_out));
            if (sample_valid) begin
               if (first_valid_edge < 0) first_valid_edge = edge_cnt;
               if (last_valid_edge >= 0) last_spacing = edge_cnt - last_valid_edge;
               last_valid_edge = edge_cnt;
               nvalid++;
               last_sample = sample_out;
            end
         end
      end
   end

   task automatic step(input logic v, input logic b);
      bit_valid = v;
      bit_in    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) step(1'b1, 1'b1);
      reset = 1'b0;
   endtask

   function automatic logic pat_bit(input int p, input int i);
      case (p)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (i % 2 == 0);
         default: return (i % 4 != 3);
      endcase
   endfunction

   task automatic feed(input int p, input int count, input int gap, input int freeze_at);
      for (int i = 0; i < count; i++) begin
         if (i == freeze_at)
            repeat (1000) step(1'b0, 1'($urandom_range(0, 1)));
         step(1'b1, pat_bit(p, i));
         repeat (gap) step(1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   logic [19:0] exp_lit [4];
   int          rel;

   initial begin
      int h2 [2*R-1];
      for (int k = 0; k < 2*R-1; k++) h2[k] = 0;
      for (int a = 0; a < R; a++)
         for (int b = 0; b < R; b++)
            h2[a+b]++;
      for (int k = 0; k < KLEN; k++) begin
         h[k] = 0;
         for (int c = 0; c < R; c++)
            if (k - c >= 0 && k - c <= 2*R-2) h[k] += h2[k-c];
      end
      exp_lit[0] = 20'h0_8000;
      exp_lit[1] = 20'hF_8000;
      exp_lit[2] = 20'h0_0000;
      exp_lit[3] = 20'h0_4000;

      // Continuous patterns: ones, zeros, alternating, 1,1,1,0.
      for (int p = 0; p < 4; p++) begin
         do_reset(5);
         rel = edge_cnt;
         feed(p, 8 * R, 0, -1);
         repeat (3) step(1'b0, 1'b0);
         check("first_latency", 32'(first_valid_edge - rel), 32'(4 * R + 1));
         check("valid_spacing", 32'(last_spacing), 32'(R));
         check("valid_count", 32'(nvalid), 32'd5);
         check("settled_value", 32'(last_sample), 32'(exp_lit[p]));
      end

      // Gapped 1-in-4 input with a 1000-cycle freeze inside frame 4.
      do_reset(5);
      feed(3, 6 * R, 3, 200);
      repeat (8) step(1'b0, 1'b0);
      check("gapped_spacing", 32'(last_spacing), 32'(4 * R));
      check("gapped_count", 32'(nvalid), 32'd3);
      check("gapped_value", 32'(last_sample), 32'h0_4000);

      // Random density and bias, then reset at bit 30 of a frame.
      do_reset(3);
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      while (nbits % R != 30)
         step(1'b1, 1'($urandom_range(0, 1)));
      reset = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      reset = 1'b0;
      check("mid_reset_out", 32'(sample_out), 32'h0);
      check("mid_reset_valid", 32'(sample_valid), 32'h0);
      for (int i = 0; i < 4000; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (3) step(1'b0, 1'b0);
      check("random_count", 32'(nvalid), 32'((frames > 3) ? frames - 3 : 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
